// File: rtl/men_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states and
// small decode helpers used by the LSU, the decoder and the EX stage.
package men_lsu_pkg;

  localparam logic [7:0] OpLb  = 8'hE0;
  localparam logic [7:0] OpLh  = 8'hE1;
  localparam logic [7:0] OpLw  = 8'hE3;
  localparam logic [7:0] OpLbu = 8'hE4;
  localparam logic [7:0] OpLhu = 8'hE5;
  localparam logic [7:0] OpSb  = 8'hE8;
  localparam logic [7:0] OpSh  = 8'hE9;
  localparam logic [7:0] OpSw  = 8'hEB;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } lsu_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; byte ops never fault.
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
    logic res;
    res = 1'b0;
    case (op)
      OpLh, OpLhu, OpSh: res = lo[0];
      OpLw, OpSw:        res = |lo;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
    logic [3:0] sel;
    sel = 4'b1111;
    case (op)
      OpLb, OpLbu, OpSb: sel = 4'b0001 << lo;
      OpLh, OpLhu, OpSh: sel = 4'b0011 << lo;
      default:           sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Replicate narrow store data across all lanes so the sel mask alone picks the target.
  function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] data);
    logic [31:0] wd;
    wd = '0;
    case (op)
      OpSb:    wd = {4{data[7:0]}};
      OpSh:    wd = {2{data[15:0]}};
      OpSw:    wd = data;
      default: wd = '0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/men_lsu_load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword from the
// little-endian bus word and sign- or zero-extends it to 32 bits.
module men_load_align
  import men_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [7:0]  op,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Extend the selected lane according to the load flavour.
  always_comb begin
    result = '0;
    case (op)
      OpLb:    result = {{24{byte_v[7]}}, byte_v};
      OpLbu:   result = {24'h0, byte_v};
      OpLh:    result = {{16{half_v[15]}}, half_v};
      OpLhu:   result = {16'h0, half_v};
      OpLw:    result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/men_lsu.sv
// MEM-stage load/store unit. Non-memory ops pass straight through; memory ops run
// an IDLE -> WAIT -> DONE handshake on the data bus while stalling the pipeline.
module men_lsu
  import men_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] men_w_reg_data,
  input  logic [4:0]  men_w_reg_addr,
  input  logic        men_wd,
  input  logic [7:0]  ex_men_aluop_o,
  input  logic [31:0] o_ex_men_inst_addr,
  input  logic [31:0] o_ex_men_data_use,
  output logic [31:0] men_o_reg_data,
  output logic [4:0]  men_o_reg_addr,
  output logic        men_o_wd,
  output logic        stall_req,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        align_err
);

  lsu_state_e  state_q;
  logic        req_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;

  logic        mem_op;
  logic        load_op;
  logic        misaligned;
  logic [31:0] load_result;

  assign mem_op     = is_mem_op(ex_men_aluop_o);
  assign load_op    = is_load_op(ex_men_aluop_o);
  assign misaligned = mem_op && is_misaligned(ex_men_aluop_o, o_ex_men_inst_addr[1:0]);

  men_load_align u_load_align (
    .rdata   (dbus_rdata),
    .addr_lo (o_ex_men_inst_addr[1:0]),
    .op      (ex_men_aluop_o),
    .result  (load_result)
  );

  // Bus handshake FSM; the EX/MEM inputs stay frozen while stall_req is high, so
  // they can be used directly when capturing the load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_op && !misaligned) begin
            state_q <= StWait;
            req_q   <= 1'b1;
            we_q    <= !load_op;
            sel_q   <= lane_sel(ex_men_aluop_o, o_ex_men_inst_addr[1:0]);
            addr_q  <= {o_ex_men_inst_addr[31:2], 2'b00};
            wdata_q <= store_wdata(ex_men_aluop_o, o_ex_men_data_use);
          end
        end
        StWait: begin
          if (dbus_ack) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= load_op ? load_result : '0;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_sel   = sel_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;

  // Writeback and stall outputs; all forced low while reset is held.
  always_comb begin
    men_o_reg_data = '0;
    men_o_reg_addr = '0;
    men_o_wd       = 1'b0;
    stall_req      = 1'b0;
    align_err      = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          men_o_reg_data = men_w_reg_data;
          men_o_reg_addr = men_w_reg_addr;
          if (!mem_op) begin
            men_o_wd = men_wd;
          end else if (misaligned) begin
            align_err = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        StWait: begin
          men_o_reg_data = men_w_reg_data;
          men_o_reg_addr = men_w_reg_addr;
          stall_req      = 1'b1;
        end
        StDone: begin
          men_o_reg_data = data_q;
          men_o_reg_addr = men_w_reg_addr;
          men_o_wd       = load_op && men_wd;
        end
        default: begin
          men_o_reg_data = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_men_lsu.sv
// Directed self-checking bench for men_lsu.
module tb_men_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] men_w_reg_data;
  logic [4:0]  men_w_reg_addr;
  logic        men_wd;
  logic [7:0]  ex_men_aluop_o;
  logic [31:0] o_ex_men_inst_addr;
  logic [31:0] o_ex_men_data_use;
  logic [31:0] men_o_reg_data;
  logic [4:0]  men_o_reg_addr;
  logic        men_o_wd;
  logic        stall_req;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        align_err;

  int n_chk = 0;
  int n_err = 0;
  int stall_cnt;

  men_lsu dut (
    .clk                (clk),
    .rst                (rst),
    .men_w_reg_data     (men_w_reg_data),
    .men_w_reg_addr     (men_w_reg_addr),
    .men_wd             (men_wd),
    .ex_men_aluop_o     (ex_men_aluop_o),
    .o_ex_men_inst_addr (o_ex_men_inst_addr),
    .o_ex_men_data_use  (o_ex_men_data_use),
    .men_o_reg_data     (men_o_reg_data),
    .men_o_reg_addr     (men_o_reg_addr),
    .men_o_wd           (men_o_wd),
    .stall_req          (stall_req),
    .dbus_req           (dbus_req),
    .dbus_we            (dbus_we),
    .dbus_sel           (dbus_sel),
    .dbus_addr          (dbus_addr),
    .dbus_wdata         (dbus_wdata),
    .dbus_ack           (dbus_ack),
    .dbus_rdata         (dbus_rdata),
    .align_err          (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b0;
    men_w_reg_data     = 32'h0000_1234;
    men_w_reg_addr     = 5'd9;
    men_wd             = 1'b1;
    ex_men_aluop_o     = 8'h20;
    o_ex_men_inst_addr = 32'h0;
    o_ex_men_data_use  = 32'h0;
    dbus_ack           = 1'b0;
    dbus_rdata         = 32'h0;

    // Reset state, before any clock edge
    #3;
    chk("rst_req", dbus_req, 0);
    chk("rst_we", dbus_we, 0);
    chk("rst_sel", dbus_sel, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_wdata", dbus_wdata, 0);
    chk("rst_odata", men_o_reg_data, 0);
    chk("rst_owd", men_o_wd, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_alerr", align_err, 0);

    // Non-memory pass-through
    @(negedge clk);
    rst            = 1'b1;
    men_w_reg_addr = 5'd5;
    #1;
    chk("add_data", men_o_reg_data, 32'h0000_1234);
    chk("add_raddr", men_o_reg_addr, 5);
    chk("add_wd", men_o_wd, 1);
    chk("add_stall", stall_req, 0);
    chk("add_req", dbus_req, 0);

    // LB, ack in first WAIT cycle
    @(negedge clk);
    ex_men_aluop_o     = 8'hE0;
    o_ex_men_inst_addr = 32'h0000_0103;
    men_w_reg_addr     = 5'd7;
    #1;
    chk("lb_stall_idle", stall_req, 1);
    chk("lb_req_idle", dbus_req, 0);
    @(negedge clk);
    #1;
    chk("lb_req", dbus_req, 1);
    chk("lb_we", dbus_we, 0);
    chk("lb_sel", dbus_sel, 4'b1000);
    chk("lb_addr", dbus_addr, 32'h0000_0100);
    chk("lb_stall_wait", stall_req, 1);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h80FF_7F01;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("lb_stall_done", stall_req, 0);
    chk("lb_req_done", dbus_req, 0);
    chk("lb_data", men_o_reg_data, 32'hFFFF_FF80);
    chk("lb_raddr", men_o_reg_addr, 7);
    chk("lb_wd", men_o_wd, 1);

    // LHU, ack after 4 wait cycles
    @(negedge clk);
    ex_men_aluop_o     = 8'hE5;
    o_ex_men_inst_addr = 32'h0000_0202;
    men_w_reg_addr     = 5'd12;
    dbus_rdata         = 32'hABCD_0000;
    #1;
    stall_cnt = int'(stall_req);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) dbus_ack = 1'b1;
      #1;
      stall_cnt += int'(stall_req);
      chk("lhu_req_wait", dbus_req, 1);
    end
    chk("lhu_sel", dbus_sel, 4'b1100);
    chk("lhu_addr", dbus_addr, 32'h0000_0200);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("lhu_stall_done", stall_req, 0);
    chk("lhu_data", men_o_reg_data, 32'h0000_ABCD);
    chk("lhu_stall_cnt", stall_cnt, 6);

    // SB
    @(negedge clk);
    ex_men_aluop_o     = 8'hE8;
    o_ex_men_inst_addr = 32'h0000_0001;
    o_ex_men_data_use  = 32'h0000_00A5;
    men_w_reg_addr     = 5'd3;
    #1;
    chk("sb_stall_idle", stall_req, 1);
    @(negedge clk);
    #1;
    chk("sb_req", dbus_req, 1);
    chk("sb_we", dbus_we, 1);
    chk("sb_sel", dbus_sel, 4'b0010);
    chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", dbus_addr, 32'h0000_0000);
    dbus_ack = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("sb_wd_done", men_o_wd, 0);
    chk("sb_stall_done", stall_req, 0);

    // Misaligned LW
    @(negedge clk);
    ex_men_aluop_o     = 8'hE3;
    o_ex_men_inst_addr = 32'h0000_0006;
    men_w_reg_addr     = 5'd4;
    #1;
    chk("lw_mis_alerr", align_err, 1);
    chk("lw_mis_stall", stall_req, 0);
    chk("lw_mis_wd", men_o_wd, 0);
    chk("lw_mis_req", dbus_req, 0);
    @(negedge clk);
    #1;
    chk("lw_mis_req_next", dbus_req, 0);
    ex_men_aluop_o = 8'h20;
    dbus_ack       = 1'b1;  // stray ack while idle
    #1;
    chk("lw_mis_alerr_clr", align_err, 0);

    // LBU to r0 still performs the read
    @(negedge clk);
    dbus_ack           = 1'b0;
    #1;
    chk("stray_ack_stall", stall_req, 0);
    chk("stray_ack_req", dbus_req, 0);
    ex_men_aluop_o     = 8'hE4;
    o_ex_men_inst_addr = 32'h0000_0000;
    men_w_reg_addr     = 5'd0;
    dbus_rdata         = 32'h1234_56FE;
    @(negedge clk);
    #1;
    chk("r0_req", dbus_req, 1);
    chk("r0_sel", dbus_sel, 4'b0001);
    dbus_ack = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("r0_data", men_o_reg_data, 32'h0000_00FE);
    chk("r0_wd", men_o_wd, 1);

    // Reset during WAIT, late ack ignored
    @(negedge clk);
    ex_men_aluop_o     = 8'hE3;
    o_ex_men_inst_addr = 32'h0000_0010;
    men_w_reg_addr     = 5'd8;
    @(negedge clk);
    #1;
    chk("rstw_req_before", dbus_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstw_req", dbus_req, 0);
    chk("rstw_sel", dbus_sel, 0);
    chk("rstw_addr", dbus_addr, 0);
    chk("rstw_stall", stall_req, 0);
    chk("rstw_wd", men_o_wd, 0);
    @(negedge clk);
    rst            = 1'b1;
    ex_men_aluop_o = 8'h20;
    men_w_reg_data = 32'h0000_0055;
    men_w_reg_addr = 5'd6;
    @(negedge clk);
    @(negedge clk);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_ack_req", dbus_req, 0);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("late_ack_data", men_o_reg_data, 32'h0000_0055);
    chk("late_ack_raddr", men_o_reg_addr, 6);
    chk("late_ack_stall", stall_req, 0);
    chk("late_ack_req2", dbus_req, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
